// File: rtl/debug_tx_serializer.sv
// debug_tx_serializer: splits debug response words into MSB-first bytes for the UART TX, with a one-word pending buffer.
module debug_tx_serializer #(
  parameter int TAM_DATA  = 32,
  parameter int TAM_ORDEN = 8,
  parameter int TAM_CNT   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_data_valid,
  input  logic [TAM_DATA-1:0]  i_data,
  input  logic                 i_tx_done,
  input  logic                 i_clear_overflow,
  output logic                 o_tx_start,
  output logic [TAM_ORDEN-1:0] o_tx_byte,
  output logic                 o_busy,
  output logic                 o_overflow,
  output logic [TAM_CNT-1:0]   o_words_sent
);
  localparam int NB = TAM_DATA / TAM_ORDEN;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [1:0] IDLE = 2'd0, START = 2'd1, WAIT = 2'd2;
  logic [1:0]          state_q, state_d;
  logic [TAM_DATA-1:0] shift_q, shift_d, pend_q, pend_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                pend_full_q, pend_full_d, overflow_q, overflow_d;
  logic [TAM_CNT-1:0]  words_q, words_d;
  logic                last, word_done;
  always_comb begin
    last        = idx_q == IW'(NB - 1);
    word_done   = state_q == WAIT && i_tx_done && last;
    state_d     = state_q;
    shift_d     = shift_q;
    idx_d       = idx_q;
    pend_full_d = pend_full_q;
    pend_d      = pend_q;
    words_d     = words_q;
    overflow_d  = overflow_q & ~i_clear_overflow;
    case (state_q)
      IDLE: if (i_data_valid) begin
        shift_d = i_data;
        idx_d   = '0;
        state_d = START;
      end
      START: state_d = WAIT;
      WAIT: if (i_tx_done) begin
        if (!last) begin
          shift_d = shift_q << TAM_ORDEN;
          idx_d   = idx_q + IW'(1);
          state_d = START;
        end else begin
          // Pending word goes first; a same-cycle valid either refills pending or starts directly.
          words_d     = words_q + TAM_CNT'(1);
          idx_d       = '0;
          state_d     = (pend_full_q || i_data_valid) ? START : IDLE;
          shift_d     = pend_full_q ? pend_q : i_data_valid ? i_data : shift_q;
          pend_full_d = pend_full_q && i_data_valid;
          pend_d      = (pend_full_q && i_data_valid) ? i_data : pend_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && i_data_valid && !word_done) begin
      pend_full_d = 1'b1;
      pend_d      = pend_full_q ? pend_q : i_data;
      overflow_d  = overflow_d | pend_full_q;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      overflow_q  <= 1'b0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      overflow_q  <= overflow_d;
      words_q     <= words_d;
    end
  end
  assign o_tx_start   = state_q == START;
  assign o_tx_byte    = shift_q[TAM_DATA-1 -: TAM_ORDEN];
  assign o_busy       = state_q != IDLE || pend_full_q;
  assign o_overflow   = overflow_q;
  assign o_words_sent = words_q;
endmodule
